ip_sdram_ctrl: RTL and testbench

Single-port SDRAM controller between the VDP's VRAM request port and an external 2M×32 SDR SDRAM (MT48LC2M32B2 class: 4 banks, 2048 rows, 256 columns). It runs power-up initialisation and periodic auto-refresh, and turns byte-addressed single-byte writes and 32-bit word reads into ACTIVE / READ-or-WRITE-with-auto-precharge sequences. It flags `sdram_init_busy` until the memory is usable.

---
 rtl/ip_sdram_ctrl_if.sv | 21 ++
 rtl/ip_sdram_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ip_sdram_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_sdram_ctrl_if.sv
// ip_sdram_ctrl_if: VRAM request port between the VDP and the SDRAM controller.
// Byte writes, 32-bit word reads, and explicit refresh requests.
interface ip_sdram_ctrl_if;
    logic [22:0] bus_address;
    logic        bus_valid;
    logic        bus_write;
    logic        bus_refresh;
    logic [7:0]  bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_rdata_en;

    modport master (
        output bus_address, bus_valid, bus_write, bus_refresh, bus_wdata,
        input  bus_rdata, bus_rdata_en
    );

    modport slave (
        input  bus_address, bus_valid, bus_write, bus_refresh, bus_wdata,
        output bus_rdata, bus_rdata_en
    );
endinterface

// File: rtl/ip_sdram_ctrl.sv
// ip_sdram_ctrl: single-port SDR SDRAM controller (2Mx32, 4 banks) for VRAM.
// Optional macro SDRAM_AUTO_REFRESH_EN adds a periodic auto-refresh timer.
module ip_sdram_ctrl #(
    parameter int FREQ = 85_909_080
) (
    input  logic           clk,
    input  logic           reset,
    output logic           sdram_init_busy,
    ip_sdram_ctrl_if.slave bus,
    output logic           O_sdram_clk,
    output logic           O_sdram_cke,
    output logic           O_sdram_cs_n,
    output logic           O_sdram_ras_n,
    output logic           O_sdram_cas_n,
    output logic           O_sdram_wen_n,
    inout  wire  [31:0]    IO_sdram_dq,
    output logic [10:0]    O_sdram_addr,
    output logic [1:0]     O_sdram_ba,
    output logic [3:0]     O_sdram_dqm
);
    localparam int INIT_CYC = FREQ / 10000;
    localparam int CNT_W    = $clog2(INIT_CYC + 1);

    localparam logic [CNT_W-1:0] C_WAIT_END = CNT_W'(INIT_CYC - 1);
    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO      = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_SEVEN    = CNT_W'(7);

    localparam logic [3:0] S_INIT_WAIT = 4'd0;
    localparam logic [3:0] S_INIT_PRE  = 4'd1;
    localparam logic [3:0] S_INIT_REF  = 4'd2;
    localparam logic [3:0] S_INIT_MRS  = 4'd3;
    localparam logic [3:0] S_IDLE      = 4'd4;
    localparam logic [3:0] S_ACT       = 4'd5;
    localparam logic [3:0] S_RW        = 4'd6;
    localparam logic [3:0] S_WAIT_DATA = 4'd7;
    localparam logic [3:0] S_REFRESH   = 4'd8;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       ref_num;
    logic [3:0]       cmd;
    logic [10:0]      addr;
    logic [1:0]       ba;
    logic [3:0]       dqm;
    logic             dq_oe;
    logic [31:0]      dq_out;
    logic             cke;
    logic [31:0]      rdata;
    logic             rdata_en;

    logic             ref_pend;
    logic             ref_tick;
    logic             ref_new;
    logic             ref_due;

    logic             pend_v;
    logic             pend_write;
    logic [22:0]      pend_addr;
    logic [7:0]       pend_wdata;

    logic             req_v;
    logic             req_write;
    logic [22:0]      req_addr;
    logic [7:0]       req_wdata;
    logic             in_idle;
    logic             start;
    logic             latch;

    logic             op_write;
    logic [7:0]       op_col;
    logic [1:0]       op_lane;
    logic [7:0]       op_wdata;

    assign O_sdram_clk  = ~clk;
    assign O_sdram_cke  = cke;
    assign {O_sdram_cs_n, O_sdram_ras_n, O_sdram_cas_n, O_sdram_wen_n} = cmd;
    assign O_sdram_addr = addr;
    assign O_sdram_ba   = ba;
    assign O_sdram_dqm  = dqm;
    assign IO_sdram_dq  = dq_oe ? dq_out : 32'hzzzz_zzzz;

    assign bus.bus_rdata    = rdata;
    assign bus.bus_rdata_en = rdata_en;

`ifdef SDRAM_AUTO_REFRESH_EN
    localparam int REF_CYC = FREQ / 64000;
    localparam int RT_W    = $clog2(REF_CYC);
    localparam logic [RT_W-1:0] RT_END = RT_W'(REF_CYC - 1);

    logic [RT_W-1:0] ref_timer;

    // Refresh interval timer; held at zero until the memory is usable.
    always_ff @(posedge clk) begin
        if (reset || sdram_init_busy)
            ref_timer <= '0;
        else if (ref_timer == RT_END)
            ref_timer <= '0;
        else
            ref_timer <= ref_timer + 1'b1;
    end

    assign ref_tick = !sdram_init_busy && (ref_timer == RT_END);
`else
    assign ref_tick = 1'b0;
`endif

    // Request arbitration: refresh beats any access, latch beats the live strobe.
    always_comb begin
        ref_new   = !sdram_init_busy && (bus.bus_refresh || ref_tick);
        ref_due   = ref_pend || ref_new;
        in_idle   = (state == S_IDLE);
        req_v     = pend_v || bus.bus_valid;
        req_write = pend_v ? pend_write : bus.bus_write;
        req_addr  = pend_v ? pend_addr  : bus.bus_address;
        req_wdata = pend_v ? pend_wdata : bus.bus_wdata;
        start     = in_idle && !ref_due && req_v;
        latch     = bus.bus_valid && !pend_v && !sdram_init_busy &&
                    !(in_idle && !ref_due);
    end

    // Refresh-pending flag, consumed when IDLE issues the REF.
    always_ff @(posedge clk) begin
        if (reset)
            ref_pend <= 1'b0;
        else if (in_idle && ref_due)
            ref_pend <= 1'b0;
        else if (ref_new)
            ref_pend <= 1'b1;
    end

    // One-entry holding latch for a request that cannot start right away.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v     <= 1'b0;
            pend_write <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (start && pend_v) begin
            pend_v <= 1'b0;
        end else if (latch) begin
            pend_v     <= 1'b1;
            pend_write <= bus.bus_write;
            pend_addr  <= bus.bus_address;
            pend_wdata <= bus.bus_wdata;
        end
    end

    // Main sequencer: init, refresh, and ACT/RW-with-auto-precharge accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_INIT_WAIT;
            cnt             <= '0;
            ref_num         <= '0;
            cmd             <= CMD_NOP;
            addr            <= '0;
            ba              <= '0;
            dqm             <= 4'hF;
            dq_oe           <= 1'b0;
            dq_out          <= '0;
            cke             <= 1'b0;
            rdata           <= '0;
            rdata_en        <= 1'b0;
            sdram_init_busy <= 1'b1;
            op_write        <= 1'b0;
            op_col          <= '0;
            op_lane         <= '0;
            op_wdata        <= '0;
        end else begin
            cmd      <= CMD_NOP;
            dqm      <= 4'hF;
            dq_oe    <= 1'b0;
            rdata_en <= 1'b0;
            cke      <= 1'b1;
            unique case (state)
                S_INIT_WAIT: begin
                    if (cnt == C_WAIT_END) begin
                        cmd   <= CMD_PRE;
                        addr  <= 11'h400;
                        state <= S_INIT_PRE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT_PRE: begin
                    if (cnt == C_ONE) begin
                        cmd     <= CMD_REF;
                        state   <= S_INIT_REF;
                        cnt     <= '0;
                        ref_num <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT_REF: begin
                    if (cnt == C_SEVEN) begin
                        cnt <= '0;
                        if (ref_num == 3'd7) begin
                            cmd   <= CMD_MRS;
                            addr  <= 11'h020;
                            state <= S_INIT_MRS;
                        end else begin
                            cmd     <= CMD_REF;
                            ref_num <= ref_num + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_INIT_MRS: begin
                    if (cnt == C_TWO) begin
                        state           <= S_IDLE;
                        cnt             <= '0;
                        sdram_init_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    cnt <= '0;
                    if (ref_due) begin
                        cmd   <= CMD_REF;
                        state <= S_REFRESH;
                    end else if (req_v) begin
                        cmd      <= CMD_ACT;
                        ba       <= req_addr[22:21];
                        addr     <= req_addr[20:10];
                        op_write <= req_write;
                        op_col   <= req_addr[9:2];
                        op_lane  <= req_addr[1:0];
                        op_wdata <= req_wdata;
                        state    <= S_ACT;
                    end
                end
                S_ACT: begin
                    if (cnt == C_ONE) begin
                        cnt   <= '0;
                        state <= S_RW;
                        addr  <= {3'b100, op_col};
                        if (op_write) begin
                            cmd    <= CMD_WRITE;
                            dqm    <= ~(4'b0001 << op_lane);
                            dq_oe  <= 1'b1;
                            dq_out <= {4{op_wdata}};
                        end else begin
                            cmd <= CMD_READ;
                            dqm <= 4'h0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RW: begin
                    state <= S_WAIT_DATA;
                    cnt   <= '0;
                end
                S_WAIT_DATA: begin
                    if (cnt == C_ONE && !op_write) begin
                        rdata    <= IO_sdram_dq;
                        rdata_en <= 1'b1;
                    end
                    if (cnt == C_TWO) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_REFRESH: begin
                    if (cnt == C_SEVEN) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_INIT_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ip_sdram_ctrl.sv
// tb_ip_sdram_ctrl: randomized bench with a behavioural SDRAM and a byte-level
// memory model of what the VRAM port should return.
module tb_ip_sdram_ctrl;
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

`ifdef SDRAM_AUTO_REFRESH_EN
    localparam int MIN_GAP = 16;
`else
    localparam int MIN_GAP = 8;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic        sclk, cke, cs_n, ras_n, cas_n, wen_n;
    wire  [31:0] dq;
    logic [10:0] addr;
    logic [1:0]  ba;
    logic [3:0]  dqm;

    ip_sdram_ctrl_if bus();

    ip_sdram_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .sdram_init_busy (busy),
        .bus             (bus),
        .O_sdram_clk     (sclk),
        .O_sdram_cke     (cke),
        .O_sdram_cs_n    (cs_n),
        .O_sdram_ras_n   (ras_n),
        .O_sdram_cas_n   (cas_n),
        .O_sdram_wen_n   (wen_n),
        .IO_sdram_dq     (dq),
        .O_sdram_addr    (addr),
        .O_sdram_ba      (ba),
        .O_sdram_dqm     (dqm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [10:0] addr;
        logic [3:0]  dqm;
        logic [31:0] dq;
    } ev_t;

    ev_t evq[$];

    // Behavioural SDRAM: samples commands on its own rising edge (clk fall).
    logic [31:0] sd_mem [int];
    logic [10:0] open_row [4];
    logic        p1_v = 1'b0, p2_v = 1'b0, tb_oe = 1'b0;
    logic [31:0] p1_d = '0, p2_d = '0, tb_d = '0;
    int          dq_bad = 0;

    assign dq = tb_oe ? tb_d : 32'hzzzz_zzzz;

    always @(negedge clk) begin
        logic [3:0]  c;
        logic [31:0] w;
        int          idx;
        ev_t         e;
        c = {cs_n, ras_n, cas_n, wen_n};
        tb_oe <= p2_v;
        tb_d  <= p2_d;
        p2_v  <= p1_v;
        p2_d  <= p1_d;
        p1_v  <= 1'b0;
        if (dut.dq_oe != (c == C_WR)) dq_bad++;
        if (c != C_NOP) begin
            e.cyc = cyc; e.cmd = c; e.ba = ba;
            e.addr = addr; e.dqm = dqm; e.dq = dq;
            evq.push_back(e);
        end
        idx = int'({ba, open_row[ba], addr[7:0]});
        if (c == C_ACT) open_row[ba] = addr;
        if (c == C_WR) begin
            w = sd_mem.exists(idx) ? sd_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (!dqm[b]) w[8*b +: 8] = dq[8*b +: 8];
            sd_mem[idx] = w;
        end
        if (c == C_RD) begin
            w = sd_mem.exists(idx) ? sd_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (dqm[b]) w[8*b +: 8] = 8'h00;
            p1_v <= 1'b1;
            p1_d <= w;
        end
    end

    logic [7:0] ref_mem [int];

    function automatic logic [31:0] exp_word(input int a);
        logic [31:0] w;
        int          b0;
        b0 = a & ~3;
        w  = '0;
        for (int b = 0; b < 4; b++)
            if (ref_mem.exists(b0 + b)) w[8*b +: 8] = ref_mem[b0 + b];
        return w;
    endfunction

    function automatic ev_t ev_at(input int i);
        ev_t e;
        e.cyc = -1; e.cmd = 4'hF; e.ba = '0;
        e.addr = '0; e.dqm = '0; e.dq = '0;
        if (i >= 0 && i < evq.size()) e = evq[i];
        return e;
    endfunction

    function automatic int find_cmd(input logic [3:0] c, input int from);
        for (int i = from; i < evq.size(); i++)
            if (evq[i].cmd == c) return i;
        return -1;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Caller sits just after an edge; strobes are held for exactly one edge.
    task automatic pulse(input logic v, input logic wr, input int a,
                         input logic [7:0] d, input logic rf);
        bus.bus_valid   = v;
        bus.bus_write   = wr;
        bus.bus_address = 23'(a);
        bus.bus_wdata   = d;
        bus.bus_refresh = rf;
        @(posedge clk);
        #1;
        bus.bus_valid   = 1'b0;
        bus.bus_refresh = 1'b0;
        if (v && wr) ref_mem[a] = d;
    endtask

    task automatic rd_wait(output logic [31:0] data, output int lat);
        lat = 1;
        while (!bus.bus_rdata_en && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        data = bus.bus_rdata;
        if (!bus.bus_rdata_en) chk("rd_timeout", 0, 1);
    endtask

    logic [31:0] rd;
    int          lat, n, ia, iw, ir, a;
    logic        wr, rf;
    logic [7:0]  d;
    logic [3:0]  init_cmds [10];

    initial begin
        bus.bus_valid   = 1'b0;
        bus.bus_write   = 1'b0;
        bus.bus_refresh = 1'b0;
        bus.bus_address = '0;
        bus.bus_wdata   = '0;

        idle(4);
        chk("rst_busy", busy, 1);
        chk("rst_rden", bus.bus_rdata_en, 0);
        chk("rst_rdata", bus.bus_rdata, 0);
        chk("rst_cmd", {cs_n, ras_n, cas_n, wen_n}, C_NOP);
        chk("rst_cke", cke, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ba", ba, 0);
        chk("rst_dqm", dqm, 4'hF);
        chk("rst_dq_oe", dut.dq_oe, 0);

        evq.delete();
        reset = 1'b0;
        n = 0;
        while (busy && n < 20000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("init_done", busy, 0);
        chk("init_long", n >= 8591, 1);
        chk("cke_on", cke, 1);
        chk("init_ncmd", evq.size(), 10);
        init_cmds[0] = C_PRE;
        for (int i = 1; i < 9; i++) init_cmds[i] = C_REF;
        init_cmds[9] = C_MRS;
        for (int i = 0; i < 10; i++)
            chk($sformatf("init_cmd%0d", i), ev_at(i).cmd, init_cmds[i]);
        chk("init_pre_a10", ev_at(0).addr[10], 1);
        for (int i = 2; i < 9; i++)
            chk($sformatf("init_ref_gap%0d", i),
                ev_at(i).cyc - ev_at(i - 1).cyc, 8);
        chk("init_mrs_addr", ev_at(9).addr, 11'h020);

        evq.delete();
        idle(3000);
        n = 0;
        for (int i = 0; i < evq.size(); i++)
            if (evq[i].cmd == C_REF) n++;
`ifdef SDRAM_AUTO_REFRESH_EN
        chk("auto_ref_count", n, 2);
        chk("auto_ref_gap", ev_at(1).cyc - ev_at(0).cyc, 1342);
`else
        chk("no_auto_ref", n, 0);
`endif

        evq.delete();
        pulse(1'b1, 1'b1, 32'h6, 8'h5A, 1'b0);
        idle(8);
        ia = find_cmd(C_ACT, 0);
        iw = find_cmd(C_WR, 0);
        chk("w1_act_ba", ev_at(ia).ba, 0);
        chk("w1_act_row", ev_at(ia).addr, 0);
        chk("w1_wr_addr", ev_at(iw).addr, 11'h401);
        chk("w1_wr_dqm", ev_at(iw).dqm, 4'b1011);
        chk("w1_wr_dq", ev_at(iw).dq, 32'h5A5A5A5A);
        chk("w1_act_to_wr", ev_at(iw).cyc - ev_at(ia).cyc, 2);

        for (int i = 0; i < 4; i++) begin
            pulse(1'b1, 1'b1, 32'h100 + i, 8'(8'h11 * (i + 1)), 1'b0);
            idle(MIN_GAP - 1);
        end
        evq.delete();
        pulse(1'b1, 1'b0, 32'h100, 8'h00, 1'b0);
        rd_wait(rd, lat);
        chk("r4_data", rd, 32'h44332211);
        chk("r4_model", rd, exp_word(32'h100));
`ifndef SDRAM_AUTO_REFRESH_EN
        chk("r4_latency", lat, 6);
`endif
        idle(1);
        chk("r4_en_one_cycle", bus.bus_rdata_en, 0);
        ir = find_cmd(C_RD, 0);
        chk("r4_rd_dqm", ev_at(ir).dqm, 4'h0);
        chk("r4_rd_a10", ev_at(ir).addr[10], 1);
        idle(8);

        evq.delete();
        pulse(1'b0, 1'b0, 0, 8'h00, 1'b1);
        idle(1);
        pulse(1'b1, 1'b0, 32'h101, 8'h00, 1'b0);
        rd_wait(rd, lat);
        chk("rref_data", rd, 32'h44332211);
        chk("rref_order", find_cmd(C_REF, 0) < find_cmd(C_ACT, 0), 1);
        idle(8);

        evq.delete();
        pulse(1'b1, 1'b0, 32'h102, 8'h00, 1'b1);
        rd_wait(rd, lat);
        chk("same_data", rd, 32'h44332211);
        ia = find_cmd(C_ACT, 0);
        chk("same_ref_first", find_cmd(C_REF, 0) < ia, 1);
        chk("same_ref_len", ev_at(ia).cyc - ev_at(find_cmd(C_REF, 0)).cyc >= 8, 1);
        idle(8);

        pulse(1'b1, 1'b1, 32'h200, 8'hA1, 1'b0);
        idle(1);
        pulse(1'b1, 1'b1, 32'h201, 8'hB2, 1'b0);
        idle(20);
        pulse(1'b1, 1'b0, 32'h200, 8'h00, 1'b0);
        rd_wait(rd, lat);
        chk("latch_data", rd, exp_word(32'h200));
        idle(8);

        for (int i = 0; i < 2048; i++) begin
            pulse(1'b1, 1'b1, i, 8'(i), 1'b0);
            idle(MIN_GAP - 1);
        end
        for (int i = 0; i < 512; i++) begin
            pulse(1'b1, 1'b0, 4 * i, 8'h00, 1'b0);
            rd_wait(rd, lat);
            chk($sformatf("seq_rd%0d", i), rd, exp_word(4 * i));
            idle(1);
        end

        for (int i = 0; i < 300; i++) begin
            a  = int'(($urandom_range(0, 3) << 21) |
                      ($urandom_range(0, 3) << 10) | $urandom_range(0, 63));
            wr = 1'($urandom_range(0, 1));
            d  = 8'($urandom);
            rf = ($urandom_range(0, 7) == 0);
            pulse(1'b1, wr, a, d, rf);
            if (!wr) begin
                rd_wait(rd, lat);
                chk($sformatf("rnd_rd%0d_a%0h", i, a), rd, exp_word(a));
            end
            idle(rf ? 24 : $urandom_range(MIN_GAP, MIN_GAP + 7));
        end

        chk("dq_only_in_write", dq_bad, 0);

        pulse(1'b1, 1'b1, 32'h300, 8'h77, 1'b0);
        idle(1);
        reset = 1'b1;
        idle(1);
        chk("mid_rst_busy", busy, 1);
        chk("mid_rst_cmd", {cs_n, ras_n, cas_n, wen_n}, C_NOP);
        chk("mid_rst_cke", cke, 0);
        chk("mid_rst_dqm", dqm, 4'hF);
        chk("mid_rst_dq_oe", dut.dq_oe, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
